// File: rtl/pr_burst_reader.sv
// AXI4 read-burst engine: splits one (address, beat count) command into 4KB-safe AR bursts
// and streams the returned beats out of a credit-managed internal FIFO.
module pr_burst_reader #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 512,
    parameter int ID_W       = 16,
    parameter int MAX_BURST  = 64,
    parameter int FIFO_DEPTH = 256,
    parameter int RID        = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_beats,
    output logic [ID_W-1:0]   arid_m,
    output logic [ADDR_W-1:0] araddr_m,
    output logic [7:0]        arlen_m,
    output logic [2:0]        arsize_m,
    output logic              arvalid_m,
    input  logic              arready_m,
    input  logic [ID_W-1:0]   rid_m,
    input  logic [DATA_W-1:0] rdata_m,
    input  logic [1:0]        rresp_m,
    input  logic              rlast_m,
    input  logic              rvalid_m,
    output logic              rready_m,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done,
    output logic              busy,
    output logic              err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       remaining;
    logic [31:0]       total;
    logic [31:0]       popped;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     fifo_count;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic              err_q;

    logic [31:0]       page_room;
    logic [31:0]       len32;
    logic              credit_ok;
    logic              cmd_hs;
    logic              ar_hs;
    logic              push;
    logic              pop;
    logic [CW-1:0]     inflight_next;
    logic [CW-1:0]     fifo_next;
    logic              unused_ok;

    assign unused_ok = ^{rid_m, rlast_m, rresp_m[0], cmd_addr[5:0]};

    // Burst length is clipped by what is left, the burst cap and the room left in the 4KB page
    assign page_room = 32'd64 - {26'd0, addr[11:6]};

    always_comb begin
        len32 = remaining;
        if (len32 > 32'(MAX_BURST)) len32 = 32'(MAX_BURST);
        if (len32 > page_room)      len32 = page_room;
    end

    // Only request what the FIFO can absorb, so the R channel never has to back-pressure
    assign credit_ok = (32'(fifo_count) + 32'(inflight) + len32) <= 32'(FIFO_DEPTH);

    assign cmd_ready = (state == S_IDLE);
    assign cmd_hs    = cmd_valid & cmd_ready;
    assign arvalid_m = (state == S_ISSUE) && credit_ok;
    assign ar_hs     = arvalid_m & arready_m;
    assign araddr_m  = addr;
    assign arlen_m   = (state == S_ISSUE) ? 8'(len32 - 32'd1) : 8'd0;
    assign arsize_m  = 3'b110;
    assign arid_m    = ID_W'(RID);
    assign rready_m  = 1'b1;

    assign push      = rvalid_m;
    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid & out_ready;
    assign out_data  = mem[rd_ptr];
    assign out_last  = out_valid && ((popped + 32'd1) == total);
    assign done      = (state == S_DONE);
    assign busy      = (state == S_ISSUE) || (state == S_DRAIN);
    assign err       = err_q;

    assign inflight_next = inflight + (ar_hs ? CW'(len32) : '0) - (push ? CW'(1) : '0);
    assign fifo_next     = fifo_count + (push ? CW'(1) : '0) - (pop ? CW'(1) : '0);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rdata_m;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            addr       <= '0;
            remaining  <= '0;
            total      <= '0;
            popped     <= '0;
            inflight   <= '0;
            fifo_count <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            err_q      <= 1'b0;
        end else begin
            inflight   <= inflight_next;
            fifo_count <= fifo_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                popped <= popped + 32'd1;
            end
            if (push && rresp_m[1]) err_q <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (cmd_hs) begin
                        addr      <= {cmd_addr[ADDR_W-1:6], 6'b0};
                        remaining <= cmd_beats;
                        total     <= cmd_beats;
                        popped    <= '0;
                        err_q     <= 1'b0;
                        state     <= (cmd_beats == 32'd0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (ar_hs) begin
                        addr      <= addr + (ADDR_W'(len32) << 6);
                        remaining <= remaining - len32;
                        if (remaining == len32) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (inflight_next == '0 && fifo_next == '0) state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pr_burst_reader.sv
// Directed bench for pr_burst_reader: a small AXI read slave returns address-derived data,
// and each scenario compares AR bursts, streamed beats and status against hand-computed values.
module tb_pr_burst_reader;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 512;
    localparam int ID_W   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_beats;
    logic [ID_W-1:0]   arid_m;
    logic [ADDR_W-1:0] araddr_m;
    logic [7:0]        arlen_m;
    logic [2:0]        arsize_m;
    logic              arvalid_m;
    logic              arready_m = 1'b1;
    logic [ID_W-1:0]   rid_m;
    logic [DATA_W-1:0] rdata_m = '0;
    logic [1:0]        rresp_m = 2'b00;
    logic              rlast_m = 1'b0;
    logic              rvalid_m = 1'b0;
    logic              rready_m;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              done;
    logic              busy;
    logic              err;

    always #5 clk = ~clk;

    pr_burst_reader dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
        .arid_m(arid_m), .araddr_m(araddr_m), .arlen_m(arlen_m), .arsize_m(arsize_m),
        .arvalid_m(arvalid_m), .arready_m(arready_m),
        .rid_m(rid_m), .rdata_m(rdata_m), .rresp_m(rresp_m), .rlast_m(rlast_m),
        .rvalid_m(rvalid_m), .rready_m(rready_m),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .done(done), .busy(busy), .err(err)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0]       ar_addr_q[$];
    int                ar_len_q[$];
    logic [DATA_W-1:0] out_data_q[$];
    logic              out_last_q[$];
    logic [63:0]       rq_addr[$];
    logic              rq_last[$];
    int                r_seq       = 0;
    int                err_idx     = -1;
    int                done_count  = 0;
    int                done_start  = 0;
    int                ar_unstable = 0;
    int                r_stall     = 0;
    logic              ar_toggle   = 1'b0;

    function automatic logic [DATA_W-1:0] beat_pattern(input logic [63:0] a);
        return {16{a[31:0] ^ 32'hA5A5A5A5}};
    endfunction

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_data(input string tag, input logic [DATA_W-1:0] observed, input logic [DATA_W-1:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed[63:0], expected[63:0]);
        end
    endtask

    // AXI read slave plus stream/handshake monitor: drive at negedge, sample what the next posedge will take
    initial begin : slave_monitor
        logic        r_took;
        logic        prev_ar_wait;
        logic [63:0] prev_addr;
        logic [7:0]  prev_len;
        logic [63:0] a;
        r_took = 1'b0;
        prev_ar_wait = 1'b0;
        prev_addr = '0;
        prev_len = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rq_addr.delete();
                rq_last.delete();
                rvalid_m = 1'b0;
                r_took = 1'b0;
                prev_ar_wait = 1'b0;
            end else begin
                if (!rvalid_m || r_took) begin
                    if (rq_addr.size() > 0) begin
                        a = rq_addr.pop_front();
                        rlast_m = rq_last.pop_front();
                        rvalid_m = 1'b1;
                        rdata_m = beat_pattern(a);
                        rresp_m = (r_seq == err_idx) ? 2'b10 : 2'b00;
                        r_seq++;
                    end else begin
                        rvalid_m = 1'b0;
                    end
                end
                arready_m = ar_toggle ? ~arready_m : 1'b1;
            end
            #1;
            if (rst) begin
                if (prev_ar_wait && (!arvalid_m || araddr_m != prev_addr || arlen_m != prev_len))
                    ar_unstable++;
                prev_ar_wait = arvalid_m && !arready_m;
                prev_addr = araddr_m;
                prev_len = arlen_m;
                if (arvalid_m && arready_m) begin
                    ar_addr_q.push_back(araddr_m);
                    ar_len_q.push_back(int'(arlen_m));
                    for (int j = 0; j <= int'(arlen_m); j++) begin
                        rq_addr.push_back(araddr_m + 64'(j * 64));
                        rq_last.push_back(j == int'(arlen_m));
                    end
                end
                r_took = rvalid_m && rready_m;
                if (rvalid_m && !rready_m) r_stall++;
                if (out_valid && out_ready) begin
                    out_data_q.push_back(out_data);
                    out_last_q.push_back(out_last);
                end
                if (done) done_count++;
                if (cmd_valid && cmd_ready) r_seq = 0;
            end
        end
    end

    task automatic apply_stimulus(input logic [63:0] a, input int beats, input int eidx);
        ar_addr_q.delete();
        ar_len_q.delete();
        out_data_q.delete();
        out_last_q.delete();
        err_idx = eidx;
        done_start = done_count;
        check_output("cmd_ready_idle", cmd_ready, 1);
        cmd_addr = a;
        cmd_beats = beats;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done_count == done_start && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output("done_seen", done_count != done_start, 1);
        repeat (3) @(negedge clk);
        check_output("done_once", done_count - done_start, 1);
    endtask

    task automatic check_stream(input logic [63:0] base, input int beats);
        check_output("beat_count", out_data_q.size(), beats);
        for (int i = 0; i < out_data_q.size(); i++) begin
            check_data("beat_data", out_data_q[i], beat_pattern(base + 64'(i * 64)));
            check_output("beat_last", out_last_q[i], (i == beats - 1));
        end
    endtask

    task automatic check_ar(input int idx, input logic [63:0] exp_addr, input int exp_len);
        if (idx < ar_addr_q.size()) begin
            check_output("ar_addr", ar_addr_q[idx], exp_addr);
            check_output("ar_len", ar_len_q[idx], exp_len);
        end else begin
            check_output("ar_present", idx, ar_addr_q.size());
        end
    endtask

    task automatic check_reset_values();
        check_output("rst_cmd_ready", cmd_ready, 1);
        check_output("rst_arvalid", arvalid_m, 0);
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_out_last", out_last, 0);
        check_output("rst_done", done, 0);
        check_output("rst_busy", busy, 0);
        check_output("rst_err", err, 0);
        check_output("rst_rready", rready_m, 1);
        check_output("rst_araddr", araddr_m, 0);
        check_output("rst_arlen", arlen_m, 0);
    endtask

    initial begin : stimulus
        int sum;
        int lat;
        cmd_valid = 1'b0;
        cmd_addr = '0;
        cmd_beats = '0;
        out_ready = 1'b1;
        rid_m = '0;

        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] single beat at 0x1000");
        apply_stimulus(64'h1000, 1, -1);
        check_output("t1_busy", busy, 1);
        check_output("t1_arvalid_next", arvalid_m, 1);
        check_output("t1_arsize", arsize_m, 3'b110);
        check_output("t1_arid", arid_m, 0);
        wait_done(100);
        check_output("t1_ar_count", ar_addr_q.size(), 1);
        check_ar(0, 64'h1000, 0);
        check_stream(64'h1000, 1);
        check_output("t1_busy_after", busy, 0);

        $display("[TB] 4KB crossing at 0x0FC0");
        apply_stimulus(64'h0FC0, 3, -1);
        wait_done(100);
        check_output("t2_ar_count", ar_addr_q.size(), 2);
        check_ar(0, 64'h0FC0, 0);
        check_ar(1, 64'h1000, 1);
        check_stream(64'h0FC0, 3);

        $display("[TB] 200 beats with toggling arready");
        ar_toggle = 1'b1;
        apply_stimulus(64'h0, 200, -1);
        wait_done(2000);
        ar_toggle = 1'b0;
        check_output("t3_ar_count", ar_addr_q.size(), 4);
        check_ar(0, 64'h0000, 63);
        check_ar(1, 64'h1000, 63);
        check_ar(2, 64'h2000, 63);
        check_ar(3, 64'h3000, 7);
        check_stream(64'h0, 200);

        $display("[TB] 300 beats with stream stalled");
        out_ready = 1'b0;
        apply_stimulus(64'h20000, 300, -1);
        repeat (400) @(negedge clk);
        sum = 0;
        foreach (ar_len_q[k]) sum += ar_len_q[k] + 1;
        check_output("t4_credited", sum, 256);
        check_output("t4_ar_count_stalled", ar_addr_q.size(), 4);
        check_output("t4_out_valid", out_valid, 1);
        check_output("t4_busy", busy, 1);
        out_ready = 1'b1;
        wait_done(2000);
        check_output("t4_ar_count", ar_addr_q.size(), 5);
        check_ar(4, 64'h24000, 43);
        check_stream(64'h20000, 300);

        $display("[TB] error response on second beat, unaligned address");
        apply_stimulus(64'h3017, 4, 1);
        wait_done(100);
        check_output("t5_ar_count", ar_addr_q.size(), 1);
        check_ar(0, 64'h3000, 3);
        check_stream(64'h3000, 4);
        repeat (5) @(negedge clk);
        check_output("t5_err_sticky", err, 1);

        $display("[TB] zero-beat command");
        apply_stimulus(64'h5000, 0, -1);
        check_output("t6_err_cleared", err, 0);
        lat = 1;
        while (!done && lat < 4) begin
            @(negedge clk);
            lat++;
        end
        check_output("t6_done_latency", (lat >= 1 && lat <= 2), 1);
        wait_done(10);
        check_output("t6_ar_count", ar_addr_q.size(), 0);
        check_output("t6_beat_count", out_data_q.size(), 0);

        $display("[TB] reset mid-burst");
        apply_stimulus(64'h40000, 100, 0);
        repeat (20) @(negedge clk);
        check_output("t7_busy_before", busy, 1);
        rst = 1'b0;
        #1;
        check_reset_values();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_output("t7_idle_after", cmd_ready, 1);
        check_output("t7_empty_after", out_valid, 0);

        check_output("ar_payload_stable", ar_unstable, 0);
        check_output("r_never_stalled", r_stall, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
